// File: rtl/mmu_pkg.sv
// Shared constants for the pipelined address translator: segment bounds,
// access-size and error encodings, config register addresses.
package mmu_pkg;

    localparam logic [3:0] KUSEG_HI = 4'h7;
    localparam logic [3:0] KSEG0_LO = 4'h8;
    localparam logic [3:0] KSEG1_LO = 4'hA;
    localparam logic [3:0] KSEG2_LO = 4'hC;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_PRIV  = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_SIZE  = 2'd3
    } err_e;

    localparam logic CFG_USEG_BASE = 1'b0;
    localparam logic CFG_CTRL      = 1'b1;

    // True when the low address bits break natural alignment for the size.
    function automatic logic align_fault(input logic [1:0] size, input logic [1:0] lo);
        logic f;
        f = 1'b0;
        if (size == SZ_HALF && lo[0])
            f = 1'b1;
        else if (size == SZ_WORD && lo != 2'b00)
            f = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/mmu_xlate_lane.sv
// One translation channel: segment decode, error check, registered response
// with valid/ready handshake, and a saturating error counter.
module mmu_xlate_lane
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_vaddr,
    input  logic [1:0]        req_size,
    input  logic              req_user,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_paddr,
    output logic              rsp_uncached,
    output logic [1:0]        rsp_err,
    input  logic [ADDR_W-1:0] useg_base,
    input  logic              map_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]        nib;
    logic [ADDR_W-5:0] low;
    logic [ADDR_W-1:0] xl_paddr;
    logic              xl_unc;
    err_e              chk_err;
    logic              accept;

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              unc_q,   unc_d;
    err_e              err_q,   err_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    assign nib = req_vaddr[ADDR_W-1 -: 4];
    assign low = req_vaddr[ADDR_W-5:0];

    always_comb begin
        xl_paddr = req_vaddr;
        xl_unc   = 1'b0;
        if (nib <= KUSEG_HI) begin
            if (map_en)
                xl_paddr = req_vaddr + useg_base;
        end else if (nib < KSEG1_LO) begin
            xl_paddr = {nib - KSEG0_LO, low};
        end else if (nib < KSEG2_LO) begin
            xl_paddr = {nib - KSEG1_LO, low};
            xl_unc   = 1'b1;
        end
    end

    // Size fault outranks alignment, which outranks privilege.
    always_comb begin
        chk_err = ERR_NONE;
        if (req_size == SZ_RSVD)
            chk_err = ERR_SIZE;
        else if (align_fault(req_size, req_vaddr[1:0]))
            chk_err = ERR_ALIGN;
        else if (req_user && req_vaddr[ADDR_W-1])
            chk_err = ERR_PRIV;
    end

    assign req_ready = !valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        valid_d = valid_q;
        paddr_d = paddr_q;
        unc_d   = unc_q;
        err_d   = err_q;
        if (accept) begin
            valid_d = 1'b1;
            err_d   = chk_err;
            paddr_d = (chk_err == ERR_NONE) ? xl_paddr : '0;
            unc_d   = (chk_err == ERR_NONE) ? xl_unc : 1'b0;
        end else if (rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    // A clear strobe on the same edge as an errored accept leaves zero.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (accept && chk_err != ERR_NONE && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            paddr_q <= '0;
            unc_q   <= 1'b0;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            paddr_q <= paddr_d;
            unc_q   <= unc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid    = valid_q;
    assign rsp_paddr    = paddr_q;
    assign rsp_uncached = unc_q;
    assign rsp_err      = err_q;
    assign err_count    = cnt_q;

endmodule

// File: rtl/mmu_xlate_pipe.sv
// Multi-channel pipelined address translator: shared config registers
// (kuseg relocation base, map enable, counter clear) broadcast to NUM_CH lanes.
module mmu_xlate_pipe
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_vaddr,
    input  logic [NUM_CH*2-1:0]      req_size,
    input  logic [NUM_CH-1:0]        req_user,
    output logic [NUM_CH-1:0]        rsp_valid,
    input  logic [NUM_CH-1:0]        rsp_ready,
    output logic [NUM_CH*ADDR_W-1:0] rsp_paddr,
    output logic [NUM_CH-1:0]        rsp_uncached,
    output logic [NUM_CH*2-1:0]      rsp_err,
    input  logic                     cfg_we,
    input  logic                     cfg_addr,
    input  logic [ADDR_W-1:0]        cfg_wdata,
    output logic [ADDR_W-1:0]        cfg_rdata,
    output logic [NUM_CH*CNT_W-1:0]  err_count
);

    logic [ADDR_W-1:0] useg_base_q, useg_base_d;
    logic              map_en_q,    map_en_d;
    logic              cnt_clr;

    // The clear bit is a pulse into the lanes, never stored.
    assign cnt_clr = cfg_we && (cfg_addr == CFG_CTRL) && cfg_wdata[1];

    always_comb begin
        useg_base_d = useg_base_q;
        map_en_d    = map_en_q;
        if (cfg_we) begin
            if (cfg_addr == CFG_USEG_BASE)
                useg_base_d = cfg_wdata;
            else
                map_en_d = cfg_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            useg_base_q <= '0;
            map_en_q    <= 1'b0;
        end else begin
            useg_base_q <= useg_base_d;
            map_en_q    <= map_en_d;
        end
    end

    assign cfg_rdata = (cfg_addr == CFG_USEG_BASE) ? useg_base_q
                                                   : {{(ADDR_W-1){1'b0}}, map_en_q};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        mmu_xlate_lane #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk          (clk),
            .resetn       (resetn),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_vaddr    (req_vaddr[g*ADDR_W +: ADDR_W]),
            .req_size     (req_size[g*2 +: 2]),
            .req_user     (req_user[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_paddr    (rsp_paddr[g*ADDR_W +: ADDR_W]),
            .rsp_uncached (rsp_uncached[g]),
            .rsp_err      (rsp_err[g*2 +: 2]),
            .useg_base    (useg_base_q),
            .map_en       (map_en_q),
            .cnt_clr      (cnt_clr),
            .err_count    (err_count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_mmu_xlate_pipe.sv
// Directed and randomized bench for mmu_xlate_pipe with a scoreboard model.
module tb_mmu_xlate_pipe;

    localparam int AW  = 32;
    localparam int NCH = 2;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*AW-1:0] req_vaddr;
    logic [NCH*2-1:0]  req_size;
    logic [NCH-1:0]    req_user;
    logic [NCH-1:0]    rsp_valid;
    logic [NCH-1:0]    rsp_ready;
    logic [NCH*AW-1:0] rsp_paddr;
    logic [NCH-1:0]    rsp_uncached;
    logic [NCH*2-1:0]  rsp_err;
    logic              cfg_we;
    logic              cfg_addr;
    logic [AW-1:0]     cfg_wdata;
    logic [AW-1:0]     cfg_rdata;
    logic [NCH*CW-1:0] err_count;

    mmu_xlate_pipe #(.ADDR_W(AW), .NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_size(req_size), .req_user(req_user),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_paddr(rsp_paddr),
        .rsp_uncached(rsp_uncached), .rsp_err(rsp_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [31:0] pa;
        logic        unc;
        logic [1:0]  err;
    } rsp_t;

    rsp_t        sb [NCH][$];
    int          cnt_m [NCH];
    logic [31:0] base_m;
    logic        men_m;
    logic [31:0] va;
    logic [1:0]  sz;
    logic        usr;
    logic        rdy_m;
    rsp_t        r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic v, input logic [31:0] a,
                           input logic [1:0] s, input logic u);
        req_valid[ch]          = v;
        req_vaddr[ch*AW +: AW] = a;
        req_size[ch*2 +: 2]    = s;
        req_user[ch]           = u;
    endtask

    function automatic logic [31:0] pa_of(input int ch);
        return rsp_paddr[ch*AW +: AW];
    endfunction

    function automatic logic [1:0] err_of(input int ch);
        return rsp_err[ch*2 +: 2];
    endfunction

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(err_count[ch*CW +: CW]);
    endfunction

    // Reference translation written from the segment map and check rules.
    function automatic rsp_t model(input logic [31:0] a, input logic [1:0] s,
                                   input logic u, input logic [31:0] base, input logic men);
        rsp_t o;
        int unsigned n;
        n = a >> 28;
        o.pa  = 32'h0;
        o.unc = 1'b0;
        if (s == 2'd3)
            o.err = 2'd3;
        else if ((s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0))
            o.err = 2'd2;
        else if (u && n >= 8)
            o.err = 2'd1;
        else
            o.err = 2'd0;
        if (o.err == 2'd0) begin
            if (n < 8)
                o.pa = men ? a + base : a;
            else if (n < 10)
                o.pa = a - 32'h8000_0000;
            else if (n < 12) begin
                o.pa  = a - 32'hA000_0000;
                o.unc = 1'b1;
            end else
                o.pa = a;
        end
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn    = 1'b0;
        req_valid = '0;
        req_vaddr = '0;
        req_size  = '0;
        req_user  = '0;
        rsp_ready = '0;
        cfg_we    = 1'b0;
        cfg_addr  = 1'b0;
        cfg_wdata = '0;
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        chk("rst_useg_base", cfg_rdata, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h3);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);

        // kseg0 / kseg1 translation
        rsp_ready = '1;
        set_req(0, 1'b1, 32'h9FC0_0010, 2'd2, 1'b0);
        tick();
        chk("k0_valid", 32'(rsp_valid[0]), 32'h1);
        chk("k0_paddr", pa_of(0), 32'h1FC0_0010);
        chk("k0_unc",   32'(rsp_uncached[0]), 32'h0);
        chk("k0_err",   32'(err_of(0)), 32'h0);
        set_req(0, 1'b1, 32'hBFC0_0010, 2'd2, 1'b0);
        tick();
        chk("k1_paddr", pa_of(0), 32'h1FC0_0010);
        chk("k1_unc",   32'(rsp_uncached[0]), 32'h1);
        req_valid[0] = 1'b0;
        tick();
        chk("drain_valid", 32'(rsp_valid[0]), 32'h0);

        // kuseg relocation and config timing
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 32'h2000_0000;
        tick();
        cfg_we = 1'b0;
        #1;
        chk("cfg_base_rd", cfg_rdata, 32'h2000_0000);
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 32'h1;
        set_req(0, 1'b1, 32'h0040_0000, 2'd2, 1'b0);
        tick();
        cfg_we = 1'b0;
        chk("map_same_edge", pa_of(0), 32'h0040_0000);
        tick();
        chk("map_on", pa_of(0), 32'h2040_0000);
        req_valid[0] = 1'b0;
        #1;
        chk("cfg_ctrl_rd", cfg_rdata, 32'h1);
        tick();

        // error priority on ch1
        set_req(1, 1'b1, 32'h8000_0002, 2'd2, 1'b0);
        tick();
        chk("e_align_err", 32'(err_of(1)), 32'h2);
        chk("e_align_pa",  pa_of(1), 32'h0);
        set_req(1, 1'b1, 32'h8000_1000, 2'd2, 1'b1);
        tick();
        chk("e_priv_err", 32'(err_of(1)), 32'h1);
        chk("e_priv_pa",  pa_of(1), 32'h0);
        set_req(1, 1'b1, 32'hA000_0001, 2'd3, 1'b1);
        tick();
        chk("e_size_err", 32'(err_of(1)), 32'h3);
        chk("e_size_unc", 32'(rsp_uncached[1]), 32'h0);
        req_valid[1] = 1'b0;
        tick();
        chk("e_cnt1", cnt_of(1), 32'd3);
        chk("e_cnt0", cnt_of(0), 32'd0);

        // backpressure then back-to-back drain
        rsp_ready[0] = 1'b0;
        set_req(0, 1'b1, 32'h0000_1000, 2'd2, 1'b0);
        tick();
        chk("bp_ready0", 32'(req_ready[0]), 32'h0);
        set_req(0, 1'b1, 32'h0000_2004, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid[0]), 32'h1);
            chk("bp_hold_paddr", pa_of(0), 32'h2000_1000);
            chk("bp_hold_ready", 32'(req_ready[0]), 32'h0);
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(req_ready[0]), 32'h1);
        tick();
        chk("b2b_1", pa_of(0), 32'h2000_2004);
        set_req(0, 1'b1, 32'h0000_3008, 2'd2, 1'b0);
        tick();
        chk("b2b_2", pa_of(0), 32'h2000_3008);
        set_req(0, 1'b1, 32'h0000_400C, 2'd2, 1'b0);
        tick();
        chk("b2b_3", pa_of(0), 32'h2000_400C);
        chk("b2b_valid", 32'(rsp_valid[0]), 32'h1);
        req_valid[0] = 1'b0;
        tick();
        chk("b2b_end", 32'(rsp_valid[0]), 32'h0);

        // randomized traffic against the scoreboard
        base_m = $urandom;
        men_m  = 1'b1;
        cnt_m[0] = 0;
        cnt_m[1] = 3;
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = base_m;
        tick();
        cfg_we = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                va = $urandom;
                if ($urandom_range(0, 3) != 0) va[1:0] = 2'b00;
                sz  = 2'($urandom_range(0, 3));
                usr = 1'($urandom_range(0, 1));
                set_req(ch, $urandom_range(0, 3) != 0, va, sz, usr);
                rsp_ready[ch] = ($urandom_range(0, 2) != 0);
            end
            #1;
            for (int ch = 0; ch < NCH; ch++) begin
                rdy_m = (sb[ch].size() == 0) || rsp_ready[ch];
                chk($sformatf("rnd_req_ready%0d", ch), 32'(req_ready[ch]), 32'(rdy_m));
                chk($sformatf("rnd_rsp_valid%0d", ch), 32'(rsp_valid[ch]), 32'(sb[ch].size() != 0));
                if (sb[ch].size() != 0) begin
                    chk($sformatf("rnd_paddr%0d", ch), pa_of(ch), sb[ch][0].pa);
                    chk($sformatf("rnd_unc%0d", ch), 32'(rsp_uncached[ch]), 32'(sb[ch][0].unc));
                    chk($sformatf("rnd_err%0d", ch), 32'(err_of(ch)), 32'(sb[ch][0].err));
                end
                chk($sformatf("rnd_cnt%0d", ch), cnt_of(ch), 32'(cnt_m[ch]));
                if (sb[ch].size() != 0 && rsp_ready[ch])
                    void'(sb[ch].pop_front());
                if (req_valid[ch] && rdy_m) begin
                    r = model(req_vaddr[ch*AW +: AW], req_size[ch*2 +: 2],
                              req_user[ch], base_m, men_m);
                    sb[ch].push_back(r);
                    if (r.err != 2'd0 && cnt_m[ch] < 255) cnt_m[ch]++;
                end
            end
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        tick();

        // counter saturation and clear-wins
        set_req(0, 1'b1, 32'h0000_0001, 2'd3, 1'b0);
        set_req(1, 1'b1, 32'h8000_0000, 2'd3, 1'b1);
        repeat (300) tick();
        chk("sat_cnt0", cnt_of(0), 32'd255);
        chk("sat_cnt1", cnt_of(1), 32'd255);
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 32'h2;
        tick();
        cfg_we = 1'b0;
        chk("clr_cnt0", cnt_of(0), 32'd0);
        chk("clr_cnt1", cnt_of(1), 32'd0);
        chk("clr_ctrl_rd", cfg_rdata, 32'h0);
        tick();
        chk("post_clr_cnt0", cnt_of(0), 32'd1);

        // reset drops a stalled response
        rsp_ready[0] = 1'b0;
        req_valid[1] = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(rsp_valid[0]), 32'h1);
        req_valid = '0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        cfg_addr = 1'b0;
        #1;
        chk("rst2_valid", 32'(rsp_valid), 32'h0);
        chk("rst2_cnt",   32'(err_count), 32'h0);
        chk("rst2_base",  cfg_rdata, 32'h0);
        chk("rst2_err",   32'(rsp_err), 32'h0);
        tick();
        chk("rst2_hold", 32'(rsp_valid), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mmu_xlate_pipe.md
Name: mmu_xlate_pipe

Overview:
Parametrised, pipelined successor to the fixed-map combinational address translator. It serves NUM_CH independent channels (e.g. ifetch, data-read, data-write). Each channel takes a virtual-address request over a valid/ready handshake and returns one registered response per request: physical address, uncached attribute and error status. The block sits between the CPU core and the AXI-Lite bridge, adds programmable kuseg relocation and alignment/privilege checks, and keeps per-channel error counters.

Parameters:
ADDR_W, 32, address width; segment decode uses bits [ADDR_W-1:ADDR_W-4]
NUM_CH, 2, number of independent translation channels
CNT_W, 8, width of each per-channel saturating error counter

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  reset, synchronous, active-low
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  per-channel request ready
req_vaddr  in  NUM_CH*ADDR_W  virtual address; channel i at [i*ADDR_W +: ADDR_W]
req_size  in  NUM_CH*2  access size: 0 byte, 1 half, 2 word, 3 reserved
req_user  in  NUM_CH  1 = user-mode access
rsp_valid  out  NUM_CH  response valid
rsp_ready  in  NUM_CH  response accepted by consumer
rsp_paddr  out  NUM_CH*ADDR_W  physical address
rsp_uncached  out  NUM_CH  1 = kseg1 (uncached) access
rsp_err  out  NUM_CH*2  0 ok, 1 privilege, 2 misaligned, 3 bad size
cfg_we  in  1  config write strobe
cfg_addr  in  1  0 = USEG_BASE, 1 = CTRL
cfg_wdata  in  ADDR_W  config write data
cfg_rdata  out  ADDR_W  combinational readback of register at cfg_addr
err_count  out  NUM_CH*CNT_W  per-channel saturating error counts

Behaviour:
- Reset: on rising edge with resetn=0, clear all rsp_valid, rsp_paddr, rsp_uncached, rsp_err, USEG_BASE, CTRL and err_count to 0. A pending response is dropped, not delivered.
- Per-channel pipeline: one output register stage. req_ready[i] = !rsp_valid[i] || rsp_ready[i], combinational.
- A request is accepted on an edge with req_valid&&req_ready. Its response is valid from the next cycle. Latency is 1 and full throughput is 1 per cycle per channel.
- Response fields stay stable while rsp_valid=1 and rsp_ready=0. rsp_valid clears on accept when no new request is taken.
- Channels are fully independent. There is no arbitration.
- Translation on the top nibble n:
  - n 0-7 (kuseg): paddr = vaddr when CTRL.map_en=0, else (vaddr + USEG_BASE) mod 2^ADDR_W. uncached=0.
  - n 8-9 (kseg0): nibble replaced by n-8, low bits unchanged. uncached=0.
  - n A-B (kseg1): nibble replaced by n-A. uncached=1.
  - n C-F (kseg2/3): identity. uncached=0.
- Error checks, in priority order:
  - size=3 gives err 3.
  - size=1 with vaddr[0]=1, or size=2 with vaddr[1:0]!=0, gives err 2.
  - req_user=1 with vaddr[ADDR_W-1]=1 gives err 1.
- On any error, rsp_paddr=0 and rsp_uncached=0. The response is still delivered with rsp_valid.
- err_count[i] increments on accept of a request whose err!=0. It saturates at 2^CNT_W-1 with no wrap.
- Config registers:
  - USEG_BASE is all ADDR_W bits.
  - CTRL bit0 = map_en. CTRL bit1 is a write-1 self-clearing "clear counters" strobe that is not stored and reads 0. Other CTRL bits read 0.
- A config write takes effect for requests accepted on later edges. A request accepted on the same edge as the write uses the old value.
- A counter clear and an increment on the same edge: clear wins, and the result is 0.

Decomposition:
- Shared package mmu_pkg holds:
  - segment nibble bounds (KUSEG_HI=4'h7, KSEG0_LO=4'h8, KSEG1_LO=4'hA, KSEG2_LO=4'hC)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - error codes ERR_NONE/ERR_PRIV/ERR_ALIGN/ERR_SIZE
  - config addresses CFG_USEG_BASE/CFG_CTRL
- Sub-module mmu_xlate_lane: one channel's decode, error check, output register, handshake and error counter. Instantiate it NUM_CH times via generate.
- Config registers live in the top level and are broadcast to all lanes.

Test Plan:
- Reset then ch0 req vaddr=0x9FC0_0010, size=2, user=0 -> next cycle rsp_paddr=0x1FC0_0010, uncached=0, err=0. The same request with vaddr 0xBFC0_0010 -> 0x1FC0_0010, uncached=1.
- Write USEG_BASE=0x2000_0000 and CTRL=1, then vaddr=0x0040_0000 -> 0x2040_0000. A request accepted on the same edge as the CTRL write -> 0x0040_0000.
- ch1 vaddr=0x8000_0002, size=2 -> err=2, paddr=0. vaddr=0x8000_0000, user=1 -> err=1. size=3 with a misaligned user kernel address -> err=3. err_count[1]=3.
- Hold rsp_ready=0 for 4 cycles with req_valid=1 -> req_ready=0 after the first accept and the response is held stable. Raise rsp_ready -> back-to-back responses, one per cycle, in order.
- Drive both channels every cycle for 300 errored requests -> err_count saturates at 255. Write CTRL=2 on the same edge as an errored accept -> count=0.
- Deassert resetn for 1 cycle with rsp_valid=1 and rsp_ready=0 -> the next cycle has rsp_valid=0, err_count=0 and USEG_BASE=0.
